spi_sample_bridge: RTL

SPI_SAMPLE_BRIDGE -- requirements
Module: spi_sample_bridge

---
 rtl/spi_sample_bridge.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/spi_sample_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sample_bridge
// Purpose  : Unpacks SPI packets into a stream of FIR samples (valid/ready)
//            and re-packs FIR results into SPI transmit packets.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sample_bridge #(
  parameter int SAMPLE_WIDTH       = 16,
  parameter int SAMPLES_PER_PACKET = 4,
  localparam int PACKET_WIDTH      = SAMPLE_WIDTH * SAMPLES_PER_PACKET
) (
  input  logic                    clkIn,
  input  logic                    nResetIn,
  input  logic [PACKET_WIDTH-1:0] packetIn,
  input  logic                    packetValidIn,
  output logic [SAMPLE_WIDTH-1:0] sampleOut,
  output logic                    sampleValidOut,
  input  logic                    sampleReadyIn,
  input  logic [SAMPLE_WIDTH-1:0] resultIn,
  input  logic                    resultValidIn,
  output logic [PACKET_WIDTH-1:0] packetOut,
  output logic                    packetReadyOut,
  output logic                    overrunOut,
  output logic                    busyOut
);

  // Index width kept at least one bit so a single-sample packet still builds.
  localparam int IDX_W = (SAMPLES_PER_PACKET > 1) ? $clog2(SAMPLES_PER_PACKET) : 1;
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(SAMPLES_PER_PACKET - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_k;
  logic [IDX_W-1:0]        r_j;
  logic [PACKET_WIDTH-1:0] r_shadow;
  logic [PACKET_WIDTH-1:0] r_acc;
  logic [PACKET_WIDTH-1:0] r_packet;
  logic [SAMPLE_WIDTH-1:0] r_sample;
  logic                    r_sample_valid;
  logic                    r_packet_ready;
  logic                    r_overrun;
  logic                    r_busy;

  logic                    w_xfer;
  logic                    w_k_last;
  logic                    w_j_last;
  logic [IDX_W-1:0]        w_next_k;
  logic [SAMPLE_WIDTH-1:0] w_next_sample;
  logic [PACKET_WIDTH-1:0] w_acc_next;

  assign w_xfer   = r_sample_valid & sampleReadyIn;
  assign w_k_last = (r_k == c_LAST);
  assign w_j_last = (r_j == c_LAST);
  assign w_next_k = r_k + IDX_W'(1);

  // Select the sample that follows the one currently presented.
  always_comb begin
    w_next_sample = '0;
    for (int i = 0; i < SAMPLES_PER_PACKET; i++) begin
      if (w_next_k == IDX_W'(i)) begin
        w_next_sample = r_shadow[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
  end

  // Accumulator with the incoming result merged into slot j, so the final
  // sample is already included when the packet register loads.
  always_comb begin
    w_acc_next = r_acc;
    for (int i = 0; i < SAMPLES_PER_PACKET; i++) begin
      if (r_j == IDX_W'(i)) begin
        w_acc_next[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = resultIn;
      end
    end
  end

  // Unpack FSM: latch a packet, then present its samples one per transfer.
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      r_state        <= ST_IDLE;
      r_k            <= '0;
      r_shadow       <= '0;
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (packetValidIn) begin
            r_shadow       <= packetIn;
            r_k            <= '0;
            r_sample       <= packetIn[SAMPLE_WIDTH-1:0];
            r_sample_valid <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (w_xfer && w_k_last) begin
            // A packet arriving exactly as the last sample leaves is chained
            // straight in, keeping the sample stream gap-free.
            if (packetValidIn) begin
              r_shadow <= packetIn;
              r_k      <= '0;
              r_sample <= packetIn[SAMPLE_WIDTH-1:0];
            end else begin
              r_k            <= '0;
              r_sample_valid <= 1'b0;
              r_busy         <= 1'b0;
              r_state        <= ST_IDLE;
            end
          end else begin
            if (w_xfer) begin
              r_k      <= w_next_k;
              r_sample <= w_next_sample;
            end
            // Any other packet during SEND is lost; flag it until reset.
            if (packetValidIn) begin
              r_overrun <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Collect path: gather results and publish only complete packets.
  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      r_j            <= '0;
      r_acc          <= '0;
      r_packet       <= '0;
      r_packet_ready <= 1'b0;
    end else begin
      r_packet_ready <= 1'b0;
      if (resultValidIn) begin
        r_acc <= w_acc_next;
        if (w_j_last) begin
          r_packet       <= w_acc_next;
          r_packet_ready <= 1'b1;
          r_j            <= '0;
        end else begin
          r_j <= r_j + IDX_W'(1);
        end
      end
    end
  end

  assign sampleOut      = r_sample;
  assign sampleValidOut = r_sample_valid;
  assign packetOut      = r_packet;
  assign packetReadyOut = r_packet_ready;
  assign overrunOut     = r_overrun;
  assign busyOut        = r_busy;

endmodule
`default_nettype wire
